// File: rtl/button_pkg.sv
// -----------------------------------------------------------------------------
// button_pkg
// Shared types and defaults for the push-button front-end.
//   btn_state_t         : debounce FSM state; bit 1 set means "button down"
//   DEBOUNCE_CYCLES_DEF : default stable-sample count for debouncing
//   LONG_CYCLES_DEF     : default hold duration for the long-press strobe
// -----------------------------------------------------------------------------
package button_pkg;

  // Encoding chosen so that bit 1 alone gives the debounced level.
  typedef enum logic [1:0] {
    RELEASED     = 2'b00,
    PRESS_WAIT   = 2'b01,
    PRESSED      = 2'b11,
    RELEASE_WAIT = 2'b10
  } btn_state_t;

  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int LONG_CYCLES_DEF     = 200;

endpackage

// File: rtl/bit_sync.sv
// -----------------------------------------------------------------------------
// bit_sync
// Two-flop synchronizer for a single asynchronous pad input.
//   clk     : destination clock
//   rst     : asynchronous active-high reset, both flops clear to 0
//   i_async : raw asynchronous input
//   o_sync  : synchronized level, two clk edges after capture
// -----------------------------------------------------------------------------
module bit_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  // First flop may go metastable; the second gives it a full cycle to settle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// Synchronizes and debounces the stopwatch push button, producing a one-cycle
// press strobe, the debounced level and (optionally) a long-press strobe.
// Optional feature macro: BUTTON_LONGPRESS_EN enables the hold counter and
// long_pulse_o; without it long_pulse_o is tied 0.
//   clk           : system clock
//   rst           : asynchronous active-high reset
//   button_raw_i  : raw pad level, asynchronous, active-high
//   press_pulse_o : one-cycle strobe per debounced press
//   level_o       : debounced button level (decoded from state only)
//   long_pulse_o  : one-cycle strobe once a press has been held LONG_CYCLES
// -----------------------------------------------------------------------------
module button_conditioner
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic button_raw_i,
  output logic press_pulse_o,
  output logic level_o,
  output logic long_pulse_o
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Reject illegal parameterisations at elaboration rather than misbehaving.
  if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 1) begin : g_badParams
    $error("button_conditioner: DEBOUNCE_CYCLES and LONG_CYCLES must be >= 1");
  end

  logic             w_s;
  btn_state_t       r_state;
  btn_state_t       w_nextState;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_nextCnt;
  logic             w_pressEvt;
  logic             r_pressPulse;

  bit_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (button_raw_i),
    .o_sync  (w_s)
  );

  // State, counter and the registered press strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= RELEASED;
      r_cnt        <= '0;
      r_pressPulse <= 1'b0;
    end else begin
      r_state      <= w_nextState;
      r_cnt        <= w_nextCnt;
      r_pressPulse <= w_pressEvt;
    end
  end

  // Each WAIT state needs DEBOUNCE_CYCLES more agreeing samples after the
  // first changed one; any disagreeing sample falls back without reporting.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_pressEvt  = 1'b0;
    case (r_state)
      RELEASED: begin
        if (w_s) begin
          w_nextState = PRESS_WAIT;
          w_nextCnt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!w_s) begin
          w_nextState = RELEASED;
        end else if (r_cnt == CNT_LAST) begin
          w_nextState = PRESSED;
          w_pressEvt  = 1'b1;
        end else begin
          w_nextCnt = r_cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!w_s) begin
          w_nextState = RELEASE_WAIT;
          w_nextCnt   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (w_s) begin
          w_nextState = PRESSED;
        end else if (r_cnt == CNT_LAST) begin
          w_nextState = RELEASED;
        end else begin
          w_nextCnt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_nextState = RELEASED;
        w_nextCnt   = '0;
      end
    endcase
  end

  assign press_pulse_o = r_pressPulse;
  assign level_o       = (r_state == PRESSED) || (r_state == RELEASE_WAIT);

`ifdef BUTTON_LONGPRESS_EN
  localparam int                HOLD_W    = $clog2(LONG_CYCLES) + 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);

  logic [HOLD_W-1:0] r_hold;
  logic              r_longPulse;

  // Hold counter only restarts on a genuine new press (from PRESS_WAIT), so a
  // release glitch returning to PRESSED cannot re-arm the long strobe.
  // Saturating at LONG_CYCLES guarantees a single long strobe per press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold      <= '0;
      r_longPulse <= 1'b0;
    end else begin
      r_longPulse <= (r_state == PRESSED) && (r_hold == HOLD_LAST);
      if (w_pressEvt) begin
        r_hold <= '0;
      end else if (r_state == PRESSED) begin
        if (r_hold != HOLD_MAX) begin
          r_hold <= r_hold + 1'b1;
        end
      end else if (r_state == RELEASED) begin
        r_hold <= '0;
      end
    end
  end

  assign long_pulse_o = r_longPulse;
`else
  assign long_pulse_o = 1'b0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
// Self-checking bench: a run-length debounce model is stepped every clock and
// compared against the DUT each cycle, alongside directed windows with
// hand-computed edge expectations and a randomized stimulus phase.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

  localparam int D = 4;
  localparam int L = 10;
`ifdef BUTTON_LONGPRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic raw;
  logic press_pulse_o;
  logic level_o;
  logic long_pulse_o;

  int testsRun    = 0;
  int testsFailed = 0;

  // Model state: two-sample input history, debounced level, length of the
  // current run of samples disagreeing with the level, and cycles held.
  bit mH1, mH2, mLevel, mPulse, mLong;
  int mRun, mHeld;

  button_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .LONG_CYCLES     (L)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .button_raw_i  (raw),
    .press_pulse_o (press_pulse_o),
    .level_o       (level_o),
    .long_pulse_o  (long_pulse_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  // The level flips once D+1 consecutive synchronized samples disagree with it.
  task automatic modelStep();
    bit sNow;
    bit pressedNow;
    if (rst) begin
      mH1 = 0; mH2 = 0; mLevel = 0; mPulse = 0; mLong = 0; mRun = 0; mHeld = 0;
    end else begin
      sNow       = mH2;
      mPulse     = 0;
      mLong      = 0;
      pressedNow = mLevel && (mRun == 0);
      if (LONG_EN && pressedNow) begin
        if (mHeld == L - 1) mLong = 1;
        if (mHeld < L) mHeld++;
      end
      if (sNow != mLevel) mRun++;
      else mRun = 0;
      if (mRun == D + 1) begin
        mLevel = sNow;
        mRun   = 0;
        if (sNow) begin
          mPulse = 1;
          mHeld  = 0;
        end
      end
      if (!mLevel) mHeld = 0;
      mH2 = mH1;
      mH1 = raw;
    end
  endtask

  initial forever begin
    @(posedge clk);
    modelStep();
  end

  // Continuous comparison of every output against the model.
  initial forever begin
    @(posedge clk);
    #2;
    checkOutput("model level", level_o, mLevel);
    checkOutput("model pulse", press_pulse_o, mPulse);
    checkOutput("model long", long_pulse_o, mLong);
  end

  // Holds raw at v for n clock edges; called and returns at a negedge.
  task automatic applyStimulus(input logic v, input int n);
    raw = v;
    repeat (n) @(negedge clk);
  endtask

  // Raw goes high now; edge 0 is the next posedge. Pulse only after edge D+2,
  // level from edge D+2, long pulse only after edge D+2+L when enabled.
  task automatic checkPressWindow(input string tag, input int edges);
    raw = 1'b1;
    for (int e = 0; e < edges; e++) begin
      @(posedge clk);
      #2;
      checkOutput({tag, " pulse"}, press_pulse_o, e == D + 2);
      checkOutput({tag, " level"}, level_o, e >= D + 2);
      checkOutput({tag, " long"}, long_pulse_o, LONG_EN && (e == D + 2 + L));
    end
    @(negedge clk);
  endtask

  task automatic checkReleaseWindow(input string tag);
    raw = 1'b0;
    for (int e = 0; e < 10; e++) begin
      @(posedge clk);
      #2;
      checkOutput({tag, " level"}, level_o, e < D + 2);
      checkOutput({tag, " pulse"}, press_pulse_o, 1'b0);
    end
    @(negedge clk);
  endtask

  task automatic checkImmediateReset(input string tag);
    rst = 1'b1;
    #1;
    checkOutput({tag, " level"}, level_o, 1'b0);
    checkOutput({tag, " pulse"}, press_pulse_o, 1'b0);
    checkOutput({tag, " long"}, long_pulse_o, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [4:0] bounce;
    rst = 1'b1;
    raw = 1'b0;
    $display("[TB] starting, D=%0d L=%0d long=%0d", D, L, LONG_EN);

    // Reset held while the pad toggles: nothing gets through.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      raw = i[0];
      #1;
      checkOutput("reset level", level_o, 1'b0);
      checkOutput("reset pulse", press_pulse_o, 1'b0);
      checkOutput("reset long", long_pulse_o, 1'b0);
    end
    @(negedge clk);
    raw = 1'b0;
    rst = 1'b0;
    applyStimulus(1'b0, 6);

    // Clean press with long hold, then clean release.
    checkPressWindow("clean press", 70);
    checkReleaseWindow("clean release");
    applyStimulus(1'b0, 4);

    // Bouncy press: 1,1,0,1,0 then stable 1.
    bounce = 5'b01011;
    for (int i = 0; i < 5; i++) begin
      raw = bounce[i];
      @(posedge clk);
      #2;
      checkOutput("bounce no pulse", press_pulse_o, 1'b0);
      @(negedge clk);
    end
    checkPressWindow("bounce press", 30);

    // Short release glitch is absorbed; long release drops the level.
    applyStimulus(1'b0, 3);
    raw = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #2;
      checkOutput("glitch level", level_o, 1'b1);
      checkOutput("glitch pulse", press_pulse_o, 1'b0);
    end
    @(negedge clk);
    applyStimulus(1'b0, 20);
    checkOutput("long release level", level_o, 1'b0);

    // Reset in PRESS_WAIT and in PRESSED with the button still held.
    applyStimulus(1'b1, 4);
    checkImmediateReset("rst press_wait");
    checkPressWindow("after rst pw", 20);
    checkImmediateReset("rst pressed");
    checkPressWindow("after rst pressed", 30);
    applyStimulus(1'b0, 12);

    // Randomized pad activity with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        applyStimulus(logic'($urandom_range(0, 1)), $urandom_range(1, 2));
        rst = 1'b0;
      end
      applyStimulus(logic'($urandom_range(0, 1)), $urandom_range(1, 12));
    end
    applyStimulus(1'b0, 10);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
